// File: rtl/vx_ibuffer_sched_if.sv
// Instruction channel between an ibuffer slot and the scheduler, and from the
// scheduler to dispatch: valid/ready handshake plus the decoded register fields.
interface vx_ibuffer_sched_if #(
  parameter int NR_BITS = 6,
  parameter int PC_W    = 32
);
  logic               valid;
  logic               ready;
  logic               wb;
  logic [NR_BITS-1:0] rd;
  logic [NR_BITS-1:0] rs1;
  logic [NR_BITS-1:0] rs2;
  logic [NR_BITS-1:0] rs3;
  logic [PC_W-1:0]    pc;

  modport master (output valid, wb, rd, rs1, rs2, rs3, pc, input ready);
  modport slave  (input valid, wb, rd, rs1, rs2, rs3, pc, output ready);
endinterface

// File: rtl/vx_ibuffer_sched.sv
// Per-slot scoreboard plus round-robin issue: picks one hazard-free instruction
// per cycle from NUM_SLOTS ibuffer channels into a single registered output.
module vx_ibuffer_sched #(
  parameter int NUM_SLOTS = 4,
  parameter int NUM_REGS  = 64,
  parameter int CNT_W     = 32,
  localparam int NR_BITS  = $clog2(NUM_REGS),
  localparam int SL_BITS  = $clog2(NUM_SLOTS),
  localparam int PC_W     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  vx_ibuffer_sched_if.slave         ibuffer_if [NUM_SLOTS],
  vx_ibuffer_sched_if.master        issue_if,
  input  logic                      wb_valid_i,
  input  logic [SL_BITS-1:0]        wb_wis_i,
  input  logic [NR_BITS-1:0]        wb_rd_i,
  output logic [CNT_W-1:0]          perf_stalls_o
);

  logic [NUM_SLOTS-1:0] in_valid, in_wb, hazard, cand;
  logic [NR_BITS-1:0]   in_rd  [NUM_SLOTS];
  logic [NR_BITS-1:0]   in_rs1 [NUM_SLOTS];
  logic [NR_BITS-1:0]   in_rs2 [NUM_SLOTS];
  logic [NR_BITS-1:0]   in_rs3 [NUM_SLOTS];
  logic [PC_W-1:0]      in_pc  [NUM_SLOTS];

  logic [NUM_SLOTS-1:0][NUM_REGS-1:0] busy_q, busy_d;
  logic [SL_BITS-1:0]   rr_q, rr_d, win, idx;
  logic                 found, can_accept, fire, stall, set_same;

  logic                 valid_q, valid_d, wb_q, wb_d;
  logic [NR_BITS-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [CNT_W-1:0]     perf_q, perf_d;

  // Hazards look only at registered busy bits; register 0 never blocks.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign in_valid[g] = ibuffer_if[g].valid;
    assign in_wb[g]    = ibuffer_if[g].wb;
    assign in_rd[g]    = ibuffer_if[g].rd;
    assign in_rs1[g]   = ibuffer_if[g].rs1;
    assign in_rs2[g]   = ibuffer_if[g].rs2;
    assign in_rs3[g]   = ibuffer_if[g].rs3;
    assign in_pc[g]    = ibuffer_if[g].pc;
    assign hazard[g]   = ((|in_rs1[g]) & busy_q[g][in_rs1[g]])
                       | ((|in_rs2[g]) & busy_q[g][in_rs2[g]])
                       | ((|in_rs3[g]) & busy_q[g][in_rs3[g]])
                       | (in_wb[g] & (|in_rd[g]) & busy_q[g][in_rd[g]]);
    assign cand[g]     = in_valid[g] & ~hazard[g];
    assign ibuffer_if[g].ready = fire && (win == SL_BITS'(g));
  end

  always_comb begin
    found = 1'b0;
    win   = rr_q;
    idx   = rr_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx = rr_q + SL_BITS'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign can_accept = ~valid_q | issue_if.ready;
  assign fire       = can_accept & found & ~reset;
  assign stall      = (|in_valid) & ~found & ~reset;
  assign set_same   = fire & in_wb[win] & (in_rd[win] == wb_rd_i) & (win == wb_wis_i);

  always_comb begin
    valid_d = valid_q & ~issue_if.ready;
    wb_d    = wb_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rs3_d   = rs3_q;
    pc_d    = pc_q;
    rr_d    = rr_q;
    if (fire) begin
      valid_d = 1'b1;
      wb_d    = in_wb[win];
      rd_d    = in_rd[win];
      rs1_d   = in_rs1[win];
      rs2_d   = in_rs2[win];
      rs3_d   = in_rs3[win];
      pc_d    = in_pc[win];
      rr_d    = win + 1'b1;
    end
  end

  // Clear first, then set: a new writer to the same entry stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i)
      busy_d[wb_wis_i][wb_rd_i] = 1'b0;
    if (fire && in_wb[win] && (in_rd[win] != '0))
      busy_d[win][in_rd[win]] = 1'b1;
  end

  always_comb begin
    perf_d = perf_q;
    if (stall && (perf_q != '1))
      perf_d = perf_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      rr_q    <= '0;
      valid_q <= 1'b0;
      wb_q    <= 1'b0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
      pc_q    <= '0;
      perf_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rs3_q   <= rs3_d;
      pc_q    <= pc_d;
      perf_q  <= perf_d;
    end
  end

  // A release racing a fresh set of the same entry is resolved by set-wins, not an error.
  always_ff @(posedge clk) begin
    if (!reset && wb_valid_i && (wb_rd_i != '0) && !set_same)
      assert (busy_q[wb_wis_i][wb_rd_i])
        else $error("writeback release of non-busy register slot=%0d rd=%0d", wb_wis_i, wb_rd_i);
  end

  assign issue_if.valid = valid_q;
  assign issue_if.wb    = wb_q;
  assign issue_if.rd    = rd_q;
  assign issue_if.rs1   = rs1_q;
  assign issue_if.rs2   = rs2_q;
  assign issue_if.rs3   = rs3_q;
  assign issue_if.pc    = pc_q;
  assign perf_stalls_o  = perf_q;

endmodule

// File: tb/tb_vx_ibuffer_sched.sv
// Directed bench for vx_ibuffer_sched: stimulus pushes expected issues into a
// queue, an independent monitor pops and compares whatever appears on issue_if.
module tb_vx_ibuffer_sched;
  typedef struct packed {
    logic [31:0] pc;
    logic        wb;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rs3;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid [4];
  instr_t      in_d [4];
  logic [3:0]  rdy;
  logic        iss_ready;
  logic        wb_valid;
  logic [1:0]  wb_wis;
  logic [5:0]  wb_rd;
  logic [31:0] perf;
  instr_t      act_i;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     exp_stalls = 0;
  instr_t exp_q [$];
  int     cnt [4];
  int     ord [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  vx_ibuffer_sched_if ibuf [4] ();
  vx_ibuffer_sched_if iss ();

  for (genvar g = 0; g < 4; g++) begin : g_drv
    assign ibuf[g].valid = in_valid[g];
    assign ibuf[g].wb    = in_d[g].wb;
    assign ibuf[g].rd    = in_d[g].rd;
    assign ibuf[g].rs1   = in_d[g].rs1;
    assign ibuf[g].rs2   = in_d[g].rs2;
    assign ibuf[g].rs3   = in_d[g].rs3;
    assign ibuf[g].pc    = in_d[g].pc;
    assign rdy[g]        = ibuf[g].ready;
  end
  assign iss.ready = iss_ready;
  assign act_i = {iss.pc, iss.wb, iss.rd, iss.rs1, iss.rs2, iss.rs3};

  vx_ibuffer_sched #(.NUM_SLOTS(4), .NUM_REGS(64), .CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .ibuffer_if    (ibuf),
    .issue_if      (iss),
    .wb_valid_i    (wb_valid),
    .wb_wis_i      (wb_wis),
    .wb_rd_i       (wb_rd),
    .perf_stalls_o (perf)
  );

  function automatic instr_t mk(input int pc, input bit wb, input int rd,
                                input int rs1, input int rs2, input int rs3);
    instr_t r;
    r.pc  = 32'(pc);
    r.wb  = wb;
    r.rd  = 6'(rd);
    r.rs1 = 6'(rs1);
    r.rs2 = 6'(rs2);
    r.rs3 = 6'(rs3);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: check readies and stall count mid-cycle, queue the expected issue.
  task automatic cyc(input logic [3:0] exp_rdy, input bit stall, input string nm);
    @(negedge clk);
    chk({nm, "_ready"}, 64'(rdy), 64'(exp_rdy));
    chk({nm, "_stalls"}, 64'(perf), 64'(exp_stalls));
    if (stall) exp_stalls++;
    for (int s = 0; s < 4; s++)
      if (exp_rdy[s]) exp_q.push_back(in_d[s]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (iss.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got pc %h expected no issue", iss.pc);
        end else begin
          chk("issue_data", 64'(act_i), 64'(exp_q[0]));
          if (iss_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; iss_ready = 1'b1;
    wb_valid = 1'b0; wb_wis = '0; wb_rd = '0;
    for (int s = 0; s < 4; s++) begin in_valid[s] = 1'b0; in_d[s] = '0; end
    in_valid[0] = 1'b1; in_d[0] = mk(99, 1, 3, 0, 0, 0);
    cyc(4'b0000, 0, "reset");
    cyc(4'b0000, 0, "reset");
    chk("reset_valid", 64'(iss.valid), 64'(0));

    // basic issue and busy set
    reset = 1'b0;
    in_d[0] = mk('h100, 1, 5, 1, 2, 0);
    cyc(4'b0001, 0, "s1");
    chk("s1_busy_0_5", 64'(dut.busy_q[0][5]), 64'(1));

    // RAW hold, release one cycle after the writeback
    in_d[0] = mk('h101, 1, 6, 5, 0, 0);
    cyc(4'b0000, 1, "s2_held");
    cyc(4'b0000, 1, "s2_held");
    wb_valid = 1'b1; wb_wis = 2'd0; wb_rd = 6'd5;
    cyc(4'b0000, 1, "s2_wb");
    wb_valid = 1'b0;
    cyc(4'b0001, 0, "s2_release");
    in_valid[0] = 1'b0;

    // round robin, rr pointer at 1 after slot 0 issued
    for (int s = 0; s < 4; s++) begin
      cnt[s] = 0; in_valid[s] = 1'b1; in_d[s] = mk(256 * s, 0, 10, 1, 2, 3);
    end
    for (int k = 0; k < 8; k++) begin
      cyc(4'(1 << ord[k]), 0, "s3_rr");
      cnt[ord[k]]++;
      in_d[ord[k]] = mk(256 * ord[k] + cnt[ord[k]], 0, 10, 1, 2, 3);
    end
    for (int s = 0; s < 4; s++) in_valid[s] = 1'b0;

    // backpressure: output held, no stall counted
    in_valid[1] = 1'b1; in_d[1] = mk('h500, 0, 0, 4, 0, 0);
    cyc(4'b0010, 0, "s4_accept");
    iss_ready = 1'b0; in_d[1] = mk('h501, 0, 0, 4, 0, 0);
    repeat (3) cyc(4'b0000, 0, "s4_hold");
    iss_ready = 1'b1;
    cyc(4'b0010, 0, "s4_resume");
    in_d[1] = mk('h502, 0, 0, 4, 0, 0);
    cyc(4'b0010, 0, "s4_resume2");
    in_valid[1] = 1'b0;

    // set and clear of the same entry in one cycle: set wins
    in_valid[2] = 1'b1; in_d[2] = mk('h600, 1, 7, 0, 0, 0);
    wb_valid = 1'b1; wb_wis = 2'd2; wb_rd = 6'd7;
    cyc(4'b0100, 0, "s5_setclr");
    chk("s5_busy_2_7", 64'(dut.busy_q[2][7]), 64'(1));
    in_d[2] = mk('h601, 1, 0, 0, 0, 0);
    wb_wis = 2'd0; wb_rd = 6'd6;
    cyc(4'b0100, 0, "s5_rd0");
    wb_valid = 1'b0;
    chk("s5_busy_2_0", 64'(dut.busy_q[2][0]), 64'(0));
    chk("s5_busy_0_6", 64'(dut.busy_q[0][6]), 64'(0));
    chk("s5_busy_2_7_kept", 64'(dut.busy_q[2][7]), 64'(1));
    in_d[2] = mk('h602, 0, 0, 0, 7, 0);
    cyc(4'b0000, 1, "s5_raw");
    cyc(4'b0000, 1, "s5_raw");
    in_valid[2] = 1'b0;

    // reset mid-operation drops the held output and the busy table
    in_valid[3] = 1'b1; in_d[3] = mk('h700, 1, 9, 0, 0, 0);
    cyc(4'b1000, 0, "s6_fire");
    iss_ready = 1'b0; in_valid[3] = 1'b0;
    chk("s6_busy_3_9", 64'(dut.busy_q[3][9]), 64'(1));
    cyc(4'b0000, 0, "s6_hold");
    reset = 1'b1;
    cyc(4'b0000, 0, "s6_rst");
    exp_q.delete();
    exp_stalls = 0;
    chk("s6_valid", 64'(iss.valid), 64'(0));
    chk("s6_busy_any", 64'(|dut.busy_q), 64'(0));
    chk("s6_perf", 64'(perf), 64'(0));
    chk("s6_rr", 64'(dut.rr_q), 64'(0));
    reset = 1'b0; iss_ready = 1'b1;

    // rr restarts at 0, old busy[3][9] no longer blocks
    in_valid[1] = 1'b1; in_d[1] = mk('h900, 0, 0, 0, 0, 0);
    in_valid[3] = 1'b1; in_d[3] = mk('h800, 0, 0, 9, 0, 0);
    cyc(4'b0010, 0, "post_rr");
    in_valid[1] = 1'b0;
    cyc(4'b1000, 0, "post_clear");
    in_valid[3] = 1'b0;

    begin
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 10) begin
        @(posedge clk); #1;
        t++;
      end
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
